// File: rtl/board_renderer.sv
// Pixel-colour stage for the Score 4 display: a 2-clock pipeline from timing counters to RGB,
// drawing the 7x6 board, the cursor disc lane and blinking winning cells.
module board_renderer #(
    parameter int unsigned X0        = 96,
    parameter int unsigned Y0        = 64,
    parameter int unsigned CELL_LOG2 = 6,
    parameter int unsigned R2        = 784,
    parameter int unsigned BLINK_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  columns,
    input  logic [9:0]  rows,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [83:0] board_state,
    input  logic [41:0] win_mask,
    input  logic [2:0]  cursor_col,
    input  logic        cursor_player,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int unsigned CELL = 1 << CELL_LOG2;
    localparam int unsigned BW   = 7 * CELL;
    localparam int unsigned BH   = 6 * CELL;

    localparam logic [9:0]         X0_C   = 10'(X0);
    localparam logic [9:0]         X1_C   = 10'(X0 + BW);
    localparam logic [9:0]         Y0_C   = 10'(Y0);
    localparam logic [9:0]         Y1_C   = 10'(Y0 + BH);
    localparam logic [CELL_LOG2:0] HALF_C = (CELL_LOG2 + 1)'(CELL / 2);
    localparam logic [12:0]        R2_C   = 13'(R2);

    // Shadow copies of game state, refreshed only during vertical blanking
    logic [83:0] r_board_sh;
    logic [41:0] r_win_sh;
    logic [2:0]  r_cur_col_sh;
    logic        r_cur_ply_sh;
    logic [7:0]  r_frame_cnt;
    logic        r_latch_prev;

    logic w_latch;
    assign w_latch = (rows == 10'd480) && (columns == 10'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board_sh   <= '0;
            r_win_sh     <= '0;
            r_cur_col_sh <= 3'd7;
            r_cur_ply_sh <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_latch_prev <= 1'b0;
        end else begin
            r_latch_prev <= w_latch;
            if (w_latch) begin
                r_board_sh   <= board_state;
                r_win_sh     <= win_mask;
                r_cur_col_sh <= cursor_col;
                r_cur_ply_sh <= cursor_player;
            end
            if (w_latch && !r_latch_prev) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Stage 1: region decode and cell-local coordinates
    logic [9:0] w_xo;
    logic [9:0] w_yo;
    logic       w_in_x;
    logic       w_board;
    logic       w_lane;
    logic       w_visible;

    assign w_xo      = columns - X0_C;
    assign w_yo      = rows - Y0_C;
    assign w_in_x    = (columns >= X0_C) && (columns < X1_C);
    assign w_board   = w_in_x && (rows >= Y0_C) && (rows < Y1_C);
    assign w_lane    = w_in_x && (rows < Y0_C);
    assign w_visible = (columns < 10'd640) && (rows < 10'd480);

    logic                 r_vis;
    logic                 r_board;
    logic                 r_lane;
    logic [2:0]           r_ccol;
    logic [2:0]           r_crow;
    logic [CELL_LOG2-1:0] r_lx;
    logic [CELL_LOG2-1:0] r_ly;
    logic                 r_hs1;
    logic                 r_vs1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vis   <= 1'b0;
            r_board <= 1'b0;
            r_lane  <= 1'b0;
            r_ccol  <= 3'd0;
            r_crow  <= 3'd0;
            r_lx    <= '0;
            r_ly    <= '0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
        end else begin
            r_vis   <= w_visible;
            r_board <= w_board;
            r_lane  <= w_lane;
            r_ccol  <= 3'(w_xo >> CELL_LOG2);
            r_crow  <= 3'(w_yo >> CELL_LOG2);
            r_lx    <= w_xo[CELL_LOG2-1:0];
            r_ly    <= w_board ? w_yo[CELL_LOG2-1:0] : rows[CELL_LOG2-1:0];
            r_hs1   <= hsync_i;
            r_vs1   <= vsync_i;
        end
    end

    // Stage 2: disc test, cell lookup and colour priority
    logic signed [CELL_LOG2:0] w_dx;
    logic signed [CELL_LOG2:0] w_dy;
    logic signed [12:0]        w_dxe;
    logic signed [12:0]        w_dye;
    logic [12:0]               w_d2;
    logic                      w_inside;
    logic [5:0]                w_idx;
    logic [1:0]                w_cell;
    logic                      w_win;
    logic [11:0]               w_rgb;

    assign w_dx     = {1'b0, r_lx} - HALF_C;
    assign w_dy     = {1'b0, r_ly} - HALF_C;
    assign w_dxe    = 13'(w_dx);
    assign w_dye    = 13'(w_dy);
    assign w_d2     = $unsigned(w_dxe * w_dxe + w_dye * w_dye);
    assign w_inside = w_d2 < R2_C;
    assign w_idx    = ({3'b000, r_crow} * 6'd7) + {3'b000, r_ccol};
    // Shifts keep out-of-board indices harmless; the result is ignored there anyway
    assign w_cell   = 2'(r_board_sh >> {w_idx, 1'b0});
    assign w_win    = 1'(r_win_sh >> w_idx);

    always_comb begin
        w_rgb = 12'h444;
        if (!r_vis) begin
            w_rgb = 12'h000;
        end else if (r_board) begin
            if (!w_inside) begin
                w_rgb = 12'h00C;
            end else if (w_win && !r_frame_cnt[BLINK_BIT]) begin
                w_rgb = 12'h000;
            end else begin
                case (w_cell)
                    2'b01:   w_rgb = 12'hF00;
                    2'b10:   w_rgb = 12'hFF0;
                    default: w_rgb = 12'h000;
                endcase
            end
        end else if (r_lane && w_inside && (r_ccol == r_cur_col_sh)) begin
            w_rgb = r_cur_ply_sh ? 12'hFF0 : 12'hF00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red     <= 4'h0;
            green   <= 4'h0;
            blue    <= 4'h0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            red     <= w_rgb[11:8];
            green   <= w_rgb[7:4];
            blue    <= w_rgb[3:0];
            hsync_o <= r_hs1;
            vsync_o <= r_vs1;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: hand-computed colours, shadow latching, blink and sync delay.
module tb_board_renderer;

    logic        clk;
    logic        rst;
    logic [9:0]  columns;
    logic [9:0]  rows;
    logic        hsync_i;
    logic        vsync_i;
    logic [83:0] board_state;
    logic [41:0] win_mask;
    logic [2:0]  cursor_col;
    logic        cursor_player;
    logic        hsync_o;
    logic        vsync_o;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    logic [11:0] rgb;
    assign rgb = {red, green, blue};

    int n_checks = 0;
    int n_errors = 0;
    int frames   = 0;

    board_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .columns       (columns),
        .rows          (rows),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .board_state   (board_state),
        .win_mask      (win_mask),
        .cursor_col    (cursor_col),
        .cursor_player (cursor_player),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel and wait out the 2-clock pipeline
    task automatic pix(input int x, input int y);
        columns = 10'(x);
        rows    = 10'(y);
        tick();
        tick();
    endtask

    // One frame-latch event held for 2 clk, as the timing generator produces it
    task automatic latch();
        columns = 10'd0;
        rows    = 10'd480;
        tick();
        tick();
        columns = 10'd10;
        rows    = 10'd10;
        tick();
        frames++;
    endtask

    logic [11:0] exp_rgb;
    logic        last_hs;
    logic        last_vs;
    int          last_col;
    int          hs_low;

    initial begin
        rst           = 1'b1;
        columns       = 10'd0;
        rows          = 10'd0;
        hsync_i       = 1'b0;
        vsync_i       = 1'b0;
        board_state   = '0;
        win_mask      = '0;
        cursor_col    = 3'd0;
        cursor_player = 1'b0;
        repeat (3) tick();
        check("reset_rgb", 32'(rgb), 32'h000);
        check("reset_hsync", 32'(hsync_o), 32'd1);
        check("reset_vsync", 32'(vsync_o), 32'd1);

        rst     = 1'b0;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        pix(10, 10);
        check("background", 32'(rgb), 32'h444);
        pix(320, 32);
        check("reset_cursor_none", 32'(rgb), 32'h444);

        // Disc centre and corner of cell (0,0)
        board_state[1:0] = 2'b01;
        pix(128, 96);
        check("unlatched_cell0", 32'(rgb), 32'h000);
        latch();
        pix(128, 96);
        check("disc_centre", 32'(rgb), 32'hF00);
        pix(99, 67);
        check("disc_corner", 32'(rgb), 32'h00C);

        // Mid-frame change of cell (5,6) must wait for the latch
        board_state[83:82] = 2'b10;
        pix(512, 416);
        check("tear_before_latch", 32'(rgb), 32'h000);
        latch();
        pix(512, 416);
        check("after_latch", 32'(rgb), 32'hFF0);
        board_state[83:82] = 2'b00;
        pix(512, 416);
        check("hold_until_latch", 32'(rgb), 32'hFF0);

        // Cursor lane
        cursor_col    = 3'd3;
        cursor_player = 1'b1;
        latch();
        pix(320, 32);
        check("cursor_yellow", 32'(rgb), 32'hFF0);
        pix(320, 2);
        check("cursor_rim", 32'(rgb), 32'h444);
        cursor_player = 1'b0;
        latch();
        pix(320, 32);
        check("cursor_red", 32'(rgb), 32'hF00);
        cursor_col = 3'd2;
        latch();
        pix(320, 32);
        check("cursor_other_col", 32'(rgb), 32'h444);
        pix(256, 32);
        check("cursor_col2", 32'(rgb), 32'hF00);
        cursor_col = 3'd7;
        latch();
        pix(256, 32);
        check("cursor_none", 32'(rgb), 32'h444);

        // Radius and region edges
        pix(165, 96);
        check("r2_inside", 32'(rgb), 32'h000);
        pix(164, 96);
        check("r2_edge", 32'(rgb), 32'h00C);
        pix(543, 96);
        check("board_right", 32'(rgb), 32'h00C);
        pix(544, 96);
        check("past_right", 32'(rgb), 32'h444);
        pix(95, 96);
        check("before_left", 32'(rgb), 32'h444);
        pix(128, 447);
        check("board_bottom", 32'(rgb), 32'h00C);
        pix(128, 448);
        check("below_board", 32'(rgb), 32'h444);
        pix(700, 100);
        check("hblank", 32'(rgb), 32'h000);
        pix(100, 500);
        check("vblank", 32'(rgb), 32'h000);

        // Win blink across 32 frames
        win_mask[0] = 1'b1;
        for (int f = 0; f < 32; f++) begin
            latch();
            exp_rgb = ((frames >> 4) & 1) != 0 ? 12'hF00 : 12'h000;
            pix(128, 96);
            check($sformatf("blink_f%0d", frames), 32'(rgb), 32'(exp_rgb));
        end

        // Sync delay and blanking over one line
        rows     = 10'd10;
        pix(10, 10);
        last_hs  = 1'b1;
        last_vs  = 1'b1;
        last_col = 10;
        hs_low   = 0;
        for (int col = 600; col < 800; col++) begin
            for (int ph = 0; ph < 2; ph++) begin
                columns = 10'(col);
                hsync_i = !(col >= 656 && col <= 751);
                vsync_i = ((col / 16) % 2) == 1;
                tick();
                check("hsync_dly", 32'(hsync_o), 32'(last_hs));
                check("vsync_dly", 32'(vsync_o), 32'(last_vs));
                if (last_col >= 640) check("blank_rgb", 32'(rgb), 32'h000);
                if (!hsync_o) hs_low++;
                last_hs  = hsync_i;
                last_vs  = vsync_i;
                last_col = col;
            end
        end
        check("hsync_low_len", 32'(hs_low), 32'd192);

        // Asynchronous reset mid-frame clears shadows
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        pix(128, 96);
        rst = 1'b1;
        #1;
        check("async_rst_rgb", 32'(rgb), 32'h000);
        check("async_rst_hs", 32'(hsync_o), 32'd1);
        tick();
        rst      = 1'b0;
        hsync_i  = 1'b1;
        vsync_i  = 1'b1;
        frames   = 0;
        win_mask = '0;
        pix(128, 96);
        check("rst_shadow_empty", 32'(rgb), 32'h000);
        latch();
        pix(128, 96);
        check("relatch_cell0", 32'(rgb), 32'hF00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Pixel-colour stage of the Score 4 video path, directly downstream of the VGA timing generator.
- Consumes the generator's column/row counters and hsync/vsync, plus game state from the game controller.
- Produces registered 12-bit RGB for a 640x480 frame showing the 7x6 board, a cursor disc above it, and blinking winning cells.
- Syncs are delayed to stay aligned with the 2-clock pixel pipeline.

Parameters:
- X0, 96, left pixel column of board.
- Y0, 64, top pixel row of board (cursor lane is rows 0..Y0-1).
- CELL_LOG2, 6, cell size 2^CELL_LOG2 = 64 px square.
- R2, 784, disc radius squared (28^2).
- BLINK_BIT, 4, frame-counter bit driving win blink (16 frames on / 16 off).

Ports:
- clk  in  1  system clock (2x pixel rate; timing counters advance every 2 clk)
- rst  in  1  asynchronous, active-high reset
- columns  in  10  horizontal counter from timing generator, 0..799
- rows  in  10  vertical counter, 0..523
- hsync_i  in  1  hsync from timing generator
- vsync_i  in  1  vsync from timing generator
- board_state  in  84  cell (r,c), r=0 top..5, c=0..6, i=r*7+c, bits [2i+1:2i]: 00 empty, 01 red, 10 yellow, 11 treated as empty
- win_mask  in  42  bit i set = cell i blinks
- cursor_col  in  3  cursor column 0..6; 7 = no cursor
- cursor_player  in  1  0 = red cursor, 1 = yellow
- hsync_o  out  1  hsync delayed 2 clk
- vsync_o  out  1  vsync delayed 2 clk
- red, green, blue  out  4 each  pixel colour

Behaviour:
- Reset: red/green/blue = 0, hsync_o = vsync_o = 1, frame counter = 0, latched board/win/cursor = 0 (cursor latch = 7).
- Frame latch: when rows==480 && columns==0, copy board_state, win_mask, cursor_col and cursor_player into shadow registers. This condition holds for 2 clk; recopying is harmless.
  - All rendering uses shadow copies only. State changes mid-frame never tear.
- Frame counter: 8-bit, increments exactly once per latch event.
  - Use the rising edge of the condition (registered previous value), not its level.
  - Wraps 255 -> 0.
- Stage 1 (clk 1):
  - Register visible = (columns<640 && rows<480).
  - Region flags: board = X0<=x<X0+448 && Y0<=y<Y0+384; lane = X0<=x<X0+448 && y<Y0.
  - Cell col = (x-X0)>>6, cell row = (y-Y0)>>6.
  - Local lx = (x-X0)&63, ly = (y-Y0)&63 (lane uses ly = y&63).
  - Delay hsync_i/vsync_i one stage.
- Stage 2 (clk 2):
  - dx = lx-32, dy = ly-32, signed 7-bit. d2 = dx*dx + dy*dy, unsigned 13-bit, no truncation. inside = d2 < R2.
  - Register RGB and delayed syncs.
  - Colour priority:
    - not visible -> 000
    - board && inside -> cell colour
    - board && !inside -> 00C (board blue)
    - lane && inside && cell col == shadow cursor_col -> F00 (player 0) or FF0 (player 1)
    - otherwise -> 444 (background)
  - Cell colour: 01 -> F00, 10 -> FF0, 00/11 -> 000 (empty hole).
  - Win blink: if win_mask bit set and frame_cnt[BLINK_BIT]==0, draw as empty (000).
- Total latency: inputs to outputs = 2 clk for both RGB and syncs, so alignment is preserved.
- Cursor col 7 draws no disc; the lane stays background.
- rst asserted mid-frame forces reset values immediately. Rendering resumes from current inputs; shadows hold reset values until the next latch event.

Test Plan:
- Reset: hold rst -> RGB 000, hsync_o/vsync_o 1. Release, drive columns=10, rows=10 -> after 2 clk RGB 444.
- Disc centre: board_state cell (0,0)=01 latched; columns=128, rows=96 -> F00 after 2 clk. columns=99, rows=67 (corner, d2=1682) -> 00C.
- Latch timing: change cell (5,6) to 10 mid-frame at rows=200. Pixel (512,416) stays 000 until rows==480/columns==0 passes, then shows FF0 next frame.
- Cursor: cursor_col=3, player=1 latched; pixel (320,32) -> FF0. cursor_col=7 -> 444.
- Blink: win_mask bit 0 set, cell 0 = 01. Pixel (128,96) shows 000 for frames with frame_cnt[4]==0 and F00 otherwise. Frame counter increments once per frame (check 32 frames).
- Sync alignment: hsync_i low at columns 656..751 -> hsync_o low exactly 2 clk later and for the same duration. Blanking at columns>=640 gives RGB 000.
